// File: rtl/pc_redirect_ctrl_if.sv
// Redirect strobes and exception requests from main control, plus the PC/EPC/vector-read controls back to the datapath.
interface pc_redirect_ctrl_if;
  logic       seq_req;
  logic       beq_req;
  logic       bne_req;
  logic       j_req;
  logic       jr_req;
  logic       eret_req;
  logic       zero;
  logic [2:0] exc_req;
  logic       vec_ready;
  logic [1:0] PCsource;
  logic       PCWrite;
  logic       EPCWrite;
  logic       vec_rd;
  logic [7:0] vec_addr;
  logic [1:0] cause;
  logic       busy;
  logic       fault;

  modport master (
    output seq_req, beq_req, bne_req, j_req, jr_req, eret_req, zero, exc_req, vec_ready,
    input  PCsource, PCWrite, EPCWrite, vec_rd, vec_addr, cause, busy, fault
  );

  modport slave (
    input  seq_req, beq_req, bne_req, j_req, jr_req, eret_req, zero, exc_req, vec_ready,
    output PCsource, PCWrite, EPCWrite, vec_rd, vec_addr, cause, busy, fault
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC source/write sequencer with exception entry (enabled by PCCTRL_EXC_EN); outputs follow a sampled strobe by one cycle.
// No backpressure: every request is dropped while busy, and a stalled vector read times out into a sticky fault.
module pc_redirect_ctrl #(
  parameter logic [7:0]  VEC_BASE     = 8'hFD,
  parameter int unsigned VEC_WAIT_MAX = 15
) (
  input logic               clk,
  input logic               reset,
  pc_redirect_ctrl_if.slave bus
);

`ifdef PCCTRL_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [3:0] WAIT_LAST = 4'(VEC_WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, EXC_SAVE, EXC_FETCH, EXC_LOAD} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [1:0] pcsource_q;
  logic       pcwrite_q;
  logic       epcwrite_q;
  logic       vec_rd_q;
  logic [7:0] vec_addr_q;
  logic [1:0] cause_q;
  logic       busy_q;
  logic       fault_q;
  logic [1:0] exc_cause;
  logic       br_taken;

  always_comb begin
    exc_cause = 2'd2;
    if (bus.exc_req[0])      exc_cause = 2'd0;
    else if (bus.exc_req[1]) exc_cause = 2'd1;
  end

  assign br_taken = (bus.beq_req && bus.zero) || (bus.bne_req && !bus.zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      pcsource_q <= 2'b11;
      pcwrite_q  <= 1'b0;
      epcwrite_q <= 1'b0;
      vec_rd_q   <= 1'b0;
      vec_addr_q <= VEC_BASE;
      cause_q    <= 2'd0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pcwrite_q  <= 1'b0;
      epcwrite_q <= 1'b0;
      case (state)
        IDLE: begin
          // An exception swallows any redirect strobe arriving in the same cycle.
          if (EXC_EN && (|bus.exc_req)) begin
            cause_q    <= exc_cause;
            vec_addr_q <= VEC_BASE + {6'd0, exc_cause};
            epcwrite_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= EXC_SAVE;
          end else if (bus.eret_req) begin
            pcsource_q <= 2'b01;
            pcwrite_q  <= 1'b1;
          end else if (bus.jr_req) begin
            pcsource_q <= 2'b10;
            pcwrite_q  <= 1'b1;
          end else if (bus.j_req) begin
            pcsource_q <= 2'b00;
            pcwrite_q  <= 1'b1;
          end else if (bus.beq_req || bus.bne_req) begin
            if (br_taken) begin
              pcsource_q <= 2'b11;
              pcwrite_q  <= 1'b1;
            end
          end else if (bus.seq_req) begin
            pcsource_q <= 2'b11;
            pcwrite_q  <= 1'b1;
          end
        end
        EXC_SAVE: begin
          vec_rd_q <= 1'b1;
          wait_cnt <= 4'd0;
          state    <= EXC_FETCH;
        end
        EXC_FETCH: begin
          if (bus.vec_ready) begin
            vec_rd_q   <= 1'b0;
            pcsource_q <= 2'b10;
            pcwrite_q  <= 1'b1;
            state      <= EXC_LOAD;
          end else if (wait_cnt == WAIT_LAST) begin
            // Give up on the handler; PC stays where it was.
            vec_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        EXC_LOAD: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PCsource = pcsource_q;
  assign bus.PCWrite  = pcwrite_q;
  assign bus.EPCWrite = epcwrite_q;
  assign bus.vec_rd   = vec_rd_q;
  assign bus.vec_addr = vec_addr_q;
  assign bus.cause    = cause_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: each driven row pushes its expected output vector, popped one cycle later.
// Exception scenarios run when PCCTRL_EXC_EN is defined; otherwise the disabled-path behaviour is checked.
module tb_pc_redirect_ctrl;
  localparam logic [5:0] SEQ  = 6'b000001;
  localparam logic [5:0] BNE  = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b001000;
  localparam logic [5:0] JR   = 6'b010000;
  localparam logic [5:0] ERET = 6'b100000;
  localparam logic [7:0] VB   = 8'hFD;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  logic [16:0] exp_q [$];

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl #(.VEC_BASE(VB), .VEC_WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] obs();
    return {bus.PCWrite, bus.PCsource, bus.EPCWrite, bus.vec_rd, bus.busy, bus.fault, bus.cause, bus.vec_addr};
  endfunction

  function automatic logic [16:0] ev(input logic pw, input logic [1:0] src, input logic epc, input logic vrd,
                                     input logic bsy, input logic flt, input logic [1:0] cs, input logic [7:0] va);
    return {pw, src, epc, vrd, bsy, flt, cs, va};
  endfunction

  function automatic logic [16:0] rv(input logic pw, input logic [1:0] src);
    return ev(pw, src, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, VB);
  endfunction

  task automatic drive(input logic [5:0] rq, input logic z, input logic [2:0] ex, input logic vr);
    {bus.eret_req, bus.jr_req, bus.j_req, bus.beq_req, bus.bne_req, bus.seq_req} = rq;
    bus.zero      = z;
    bus.exc_req   = ex;
    bus.vec_ready = vr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(6'd0, 1'b0, 3'b000, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== rv(1'b0, 2'b11)) $display("FAIL reset_low: got %h expected %h", obs(), rv(1'b0, 2'b11));
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== rv(1'b0, 2'b11)) $display("FAIL reset_release: got %h expected %h", obs(), rv(1'b0, 2'b11));
    else passes++;
  endtask

  task automatic test_seq();
    logic [5:0]  rq [2];
    logic [16:0] e  [2];
    logic [16:0] exp_v;
    rq = '{SEQ, 6'd0};
    e  = '{rv(1'b1, 2'b11), rv(1'b0, 2'b11)};
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) $display("FAIL seq row %0d: got %h expected %h", i - 1, obs(), exp_v);
        else passes++;
      end
      if (i < 2) begin drive(rq[i], 1'b0, 3'b000, 1'b0); exp_q.push_back(e[i]); end
      else drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  rq [5];
    logic        z  [5];
    logic [16:0] e  [5];
    logic [16:0] exp_v;
    rq = '{J, BEQ, BNE, BEQ, BNE};
    z  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    e  = '{rv(1'b1, 2'b00), rv(1'b0, 2'b00), rv(1'b1, 2'b11), rv(1'b1, 2'b11), rv(1'b0, 2'b11)};
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) $display("FAIL branch row %0d: got %h expected %h", i - 1, obs(), exp_v);
        else passes++;
      end
      if (i < 5) begin drive(rq[i], z[i], 3'b000, 1'b0); exp_q.push_back(e[i]); end
      else drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
  endtask

  task automatic test_jump_priority();
    logic [5:0]  rq [4];
    logic [16:0] e  [4];
    logic [16:0] exp_v;
    rq = '{J | JR, 6'd0, ERET | JR | J | BEQ | SEQ, 6'd0};
    e  = '{rv(1'b1, 2'b10), rv(1'b0, 2'b10), rv(1'b1, 2'b01), rv(1'b0, 2'b01)};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) $display("FAIL jump_priority row %0d: got %h expected %h", i - 1, obs(), exp_v);
        else passes++;
      end
      if (i < 4) begin drive(rq[i], 1'b1, 3'b000, 1'b0); exp_q.push_back(e[i]); end
      else drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  rq [6];
    logic [16:0] e  [6];
    logic [16:0] exp_v;
    rq = '{SEQ, J, ERET, JR, BNE, 6'd0};
    e  = '{rv(1'b1, 2'b11), rv(1'b1, 2'b00), rv(1'b1, 2'b01), rv(1'b1, 2'b10), rv(1'b1, 2'b11), rv(1'b0, 2'b11)};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) $display("FAIL back_to_back row %0d: got %h expected %h", i - 1, obs(), exp_v);
        else passes++;
      end
      if (i < 6) begin drive(rq[i], 1'b0, 3'b000, 1'b0); exp_q.push_back(e[i]); end
      else drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
  endtask

`ifdef PCCTRL_EXC_EN
  task automatic test_exception();
    logic [5:0]  rq [7];
    logic [2:0]  ex [7];
    logic        vr [7];
    logic [16:0] e  [7];
    logic [16:0] exp_v;
    rq = '{SEQ, SEQ, 6'd0, 6'd0, SEQ, SEQ, 6'd0};
    ex = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e  = '{ev(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'hFE),
           ev(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hFE),
           ev(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hFE),
           ev(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'hFE),
           ev(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'hFE),
           ev(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'hFE),
           ev(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'hFE)};
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) $display("FAIL exception row %0d: got %h expected %h", i - 1, obs(), exp_v);
        else passes++;
      end
      if (i < 7) begin drive(rq[i], 1'b0, ex[i], vr[i]); exp_q.push_back(e[i]); end
      else drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
  endtask

  task automatic test_timeout();
    int nrd;
    int npw;
    logic [16:0] exp_v;
    nrd = 0;
    npw = 0;
    @(negedge clk);
    drive(6'd0, 1'b0, 3'b001, 1'b0);
    @(negedge clk);
    drive(6'd0, 1'b0, 3'b000, 1'b0);
    checks++;
    exp_v = ev(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, VB);
    if (obs() !== exp_v) $display("FAIL timeout_save: got %h expected %h", obs(), exp_v);
    else passes++;
    for (int i = 0; i < 40 && bus.fault !== 1'b1; i++) begin
      @(negedge clk);
      if (bus.vec_rd === 1'b1) nrd++;
      if (bus.PCWrite === 1'b1) npw++;
    end
    checks++;
    if (nrd !== 15) $display("FAIL timeout_fetch_cycles: got %0d expected 15", nrd);
    else passes++;
    checks++;
    if (npw !== 0) $display("FAIL timeout_no_pcwrite: got %0d pulses expected 0", npw);
    else passes++;
    checks++;
    exp_v = ev(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, VB);
    if (obs() !== exp_v) $display("FAIL timeout_fault: got %h expected %h", obs(), exp_v);
    else passes++;
    drive(SEQ, 1'b0, 3'b000, 1'b0);
    exp_q.push_back(ev(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, VB));
    @(negedge clk);
    drive(6'd0, 1'b0, 3'b000, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs() !== exp_v) $display("FAIL timeout_seq_after: got %h expected %h", obs(), exp_v);
    else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    logic [16:0] exp_v;
    @(negedge clk);
    drive(6'd0, 1'b0, 3'b100, 1'b0);
    repeat (3) begin
      @(negedge clk);
      drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
    checks++;
    exp_v = ev(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hFF);
    if (obs() !== exp_v) $display("FAIL mid_fetch_state: got %h expected %h", obs(), exp_v);
    else passes++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== rv(1'b0, 2'b11)) $display("FAIL mid_fetch_reset: got %h expected %h", obs(), rv(1'b0, 2'b11));
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    drive(SEQ, 1'b0, 3'b000, 1'b0);
    exp_q.push_back(rv(1'b1, 2'b11));
    @(negedge clk);
    drive(6'd0, 1'b0, 3'b000, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs() !== exp_v) $display("FAIL mid_fetch_seq_after: got %h expected %h", obs(), exp_v);
    else passes++;
  endtask
`else
  task automatic test_exc_disabled();
    logic [5:0]  rq [4];
    logic [16:0] e  [4];
    logic [16:0] exp_v;
    rq = '{SEQ, ERET, 6'd0, 6'd0};
    e  = '{rv(1'b1, 2'b11), rv(1'b1, 2'b01), rv(1'b0, 2'b01), rv(1'b0, 2'b01)};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs() !== exp_v) $display("FAIL exc_disabled row %0d: got %h expected %h", i - 1, obs(), exp_v);
        else passes++;
      end
      if (i < 4) begin drive(rq[i], 1'b0, 3'b111, 1'b1); exp_q.push_back(e[i]); end
      else drive(6'd0, 1'b0, 3'b000, 1'b0);
    end
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_seq();
    test_branch();
    test_jump_priority();
    test_back_to_back();
`ifdef PCCTRL_EXC_EN
    test_exception();
    test_timeout();
    test_reset_mid_fetch();
`else
    test_exc_disabled();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
